// File: rtl/fcmp_pkg.sv
// Shared types and helpers for the round-robin float compare arbiter.
// Used by fcmp_arbiter and flt.
package fcmp_pkg;

    localparam int FLT_W = 32;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic [FLT_W-1:0] x1;
        logic [FLT_W-1:0] x2;
    } fcmp_req_t;

    function automatic logic is_nan(input logic [FLT_W-1:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] != '0);
    endfunction

endpackage

// File: rtl/flt.sv
// Combinational single-precision less-than: y = (a < b) with IEEE-754 ordering.
// NaN operands give 0 and the two zeros compare equal.
module flt
    import fcmp_pkg::*;
(
    input  logic [FLT_W-1:0] a,
    input  logic [FLT_W-1:0] b,
    output logic             y
);

    logic any_nan;
    logic both_zero;
    logic mag_lt;
    logic mag_gt;

    assign any_nan   = is_nan(a) || is_nan(b);
    assign both_zero = (a[30:0] == '0) && (b[30:0] == '0);
    // Sign-magnitude encoding orders like an unsigned integer within one sign,
    // which also covers denormals and infinities.
    assign mag_lt    = a[30:0] < b[30:0];
    assign mag_gt    = a[30:0] > b[30:0];

    always_comb begin
        y = 1'b0;
        if (!any_nan && !both_zero) begin
            if (a[31] != b[31]) begin
                y = a[31];
            end else if (a[31]) begin
                y = mag_gt;
            end else begin
                y = mag_lt;
            end
        end
    end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one flt comparator among NREQ requesters, two-stage pipeline.
// Optional NaN flag output enabled by defining FCMP_ARB_NAN_EXC_EN.
module fcmp_arbiter
    import fcmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*FLT_W-1:0] req_x1,
    input  logic [NREQ*FLT_W-1:0] req_x2,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
`ifdef FCMP_ARB_NAN_EXC_EN
    output logic                  resp_exception,
`endif
    output logic                  resp_y
);

    localparam logic [IDW+1:0] NREQ_W = (IDW+2)'(NREQ);

    logic [IDW-1:0]   last_grant_reg;
    logic             s1_valid_reg;
    fcmp_req_t        s1_req_reg;
    logic [IDW-1:0]   s1_id_reg;
    logic             resp_valid_reg;
    logic [IDW-1:0]   resp_id_reg;
    logic             resp_y_reg;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic             s1_y;

    fcmp_req_t        req_arr [NREQ];
    logic [2*NREQ-1:0] dbl_shift;
    logic [NREQ-1:0]  rot_valid;
    logic [IDW:0]     rot_sh;
    logic [IDW+1:0]   grant_off;
    logic [IDW+1:0]   grant_sum;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;

    assign s2_adv = !resp_valid_reg || resp_ready;
    assign s1_adv = !s1_valid_reg || s2_adv;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_arr[gi].x1 = req_x1[FLT_W*gi +: FLT_W];
            assign req_arr[gi].x2 = req_x2[FLT_W*gi +: FLT_W];
            assign req_ready[gi]  = accept && (grant_id == IDW'(gi));
        end
    endgenerate

    // Rotate so the requester after last_grant sits at bit 0, pick the lowest
    // set bit, then map the offset back to an absolute requester index.
    always_comb begin
        rot_sh      = {1'b0, last_grant_reg} + (IDW+1)'(1);
        dbl_shift   = {req_valid, req_valid} >> rot_sh;
        rot_valid   = NREQ'(dbl_shift);
        grant_off   = '0;
        grant_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot_valid[i]) begin
                grant_off   = (IDW+2)'(i);
                grant_found = 1'b1;
            end
        end
        grant_sum = {1'b0, rot_sh} + grant_off;
        if (grant_sum >= NREQ_W) begin
            grant_sum = grant_sum - NREQ_W;
        end
        grant_id = IDW'(grant_sum);
    end

    assign accept = grant_found && s1_adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= IDW'(NREQ - 1);
            s1_valid_reg   <= 1'b0;
            s1_req_reg     <= '0;
            s1_id_reg      <= '0;
        end else if (accept) begin
            last_grant_reg <= grant_id;
            s1_valid_reg   <= 1'b1;
            s1_req_reg     <= req_arr[grant_id];
            s1_id_reg      <= grant_id;
        end else if (s1_adv) begin
            s1_valid_reg   <= 1'b0;
        end
    end

    flt u_flt (
        .a (s1_req_reg.x1),
        .b (s1_req_reg.x2),
        .y (s1_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= '0;
            resp_y_reg     <= 1'b0;
        end else if (s2_adv) begin
            resp_valid_reg <= s1_valid_reg;
            resp_id_reg    <= s1_id_reg;
            resp_y_reg     <= s1_y;
        end
    end

`ifdef FCMP_ARB_NAN_EXC_EN
    logic s1_nan;
    logic resp_exc_reg;

    assign s1_nan = is_nan(s1_req_reg.x1) || is_nan(s1_req_reg.x2);

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_exc_reg <= 1'b0;
        end else if (s2_adv) begin
            resp_exc_reg <= s1_nan;
        end
    end

    assign resp_exception = resp_exc_reg;
`endif

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_y     = resp_y_reg;

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed bench for fcmp_arbiter: reset, single request, fairness, backpressure,
// compare corner cases and reset mid-flight.
module tb_fcmp_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_x1;
    logic [NREQ*32-1:0] req_x2;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic              resp_y;
`ifdef FCMP_ARB_NAN_EXC_EN
    logic              resp_exception;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fcmp_arbiter #(.NREQ(NREQ)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_x1         (req_x1),
        .req_x2         (req_x2),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
`ifdef FCMP_ARB_NAN_EXC_EN
        .resp_exception (resp_exception),
`endif
        .resp_y         (resp_y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b);
        req_x1[32*k +: 32] = a;
        req_x2[32*k +: 32] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] b;
        logic        y;
        logic        e;
    } vec_t;

    vec_t vecs [8] = '{
        '{1, 32'h80000000, 32'h00000000, 1'b0, 1'b0},
        '{2, 32'h00000000, 32'h80000000, 1'b0, 1'b0},
        '{3, 32'hFF800000, 32'h7F7FFFFF, 1'b1, 1'b0},
        '{0, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0},
        '{1, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1},
        '{2, 32'h00000001, 32'h00000002, 1'b1, 1'b0},
        '{3, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0},
        '{0, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0}
    };

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_x1     = '0;
        req_x2     = '0;
        resp_ready = 1'b1;

        // Reset state, with requests pending to show ready is gated by rst
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rvalid", 32'(resp_valid), 32'h0);
        check("rst_rid", 32'(resp_id), 32'h0);
        check("rst_ry", 32'(resp_y), 32'h0);

        // Single request from requester 2: 1.0 < 2.0
        rst       = 1'b0;
        req_valid = 4'b0100;
        set_op(2, 32'h3F800000, 32'h40000000);
        #1;
        check("t1_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("t1_lat_rvalid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        #1;
        check("t1_rvalid", 32'(resp_valid), 32'h1);
        check("t1_rid", 32'(resp_id), 32'h2);
        check("t1_ry", 32'(resp_y), 32'h1);
        @(negedge clk);
        #1;
        check("t1_drain", 32'(resp_valid), 32'h0);

        // Fairness: all valid, x1=k, x2=2 (denormals) so y = (k < 2)
        do_reset();
        resp_ready = 1'b1;
        for (int k = 0; k < NREQ; k++) set_op(k, 32'(k), 32'h2);
        req_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("rr_grant%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
            if (i >= 2) begin
                check($sformatf("rr_rvalid%0d", i), 32'(resp_valid), 32'h1);
                check($sformatf("rr_rid%0d", i), 32'(resp_id), 32'((i - 2) % 4));
                check($sformatf("rr_ry%0d", i), 32'(resp_y), 32'(((i - 2) % 4) < 2));
            end
            @(negedge clk);
        end
        req_valid = '0;

        // Backpressure: P (1<2) then Q (2<1) enter, output stalls 5 cycles
        do_reset();
        resp_ready = 1'b0;
        set_op(0, 32'h3F800000, 32'h40000000);
        set_op(1, 32'h40000000, 32'h3F800000);
        set_op(2, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0001;
        #1;
        check("bp_ready_p", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        check("bp_ready_q", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp_hold_ready%0d", i), 32'(req_ready), 32'h0);
            check($sformatf("bp_hold_rvalid%0d", i), 32'(resp_valid), 32'h1);
            check($sformatf("bp_hold_rid%0d", i), 32'(resp_id), 32'h0);
            check($sformatf("bp_hold_ry%0d", i), 32'(resp_y), 32'h1);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        req_valid  = '0;
        #1;
        check("bp_rel_rid0", 32'(resp_id), 32'h0);
        @(negedge clk);
        #1;
        check("bp_rel_rvalid1", 32'(resp_valid), 32'h1);
        check("bp_rel_rid1", 32'(resp_id), 32'h1);
        check("bp_rel_ry1", 32'(resp_y), 32'h0);
        @(negedge clk);
        #1;
        check("bp_rel_empty", 32'(resp_valid), 32'h0);

        // Compare corner cases, one request at a time
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            set_op(vecs[v].k, vecs[v].a, vecs[v].b);
            req_valid = 4'(1 << vecs[v].k);
            #1;
            check($sformatf("cmp%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].k));
            @(negedge clk);
            req_valid = '0;
            @(negedge clk);
            #1;
            check($sformatf("cmp%0d_rvalid", v), 32'(resp_valid), 32'h1);
            check($sformatf("cmp%0d_rid", v), 32'(resp_id), 32'(vecs[v].k));
            check($sformatf("cmp%0d_y", v), 32'(resp_y), 32'(vecs[v].y));
`ifdef FCMP_ARB_NAN_EXC_EN
            check($sformatf("cmp%0d_exc", v), 32'(resp_exception), 32'(vecs[v].e));
`endif
        end

        // Reset mid-flight with s1 and output both full
        do_reset();
        resp_ready = 1'b0;
        req_valid  = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0010;
        @(negedge clk);
        #1;
        check("mr_pre_rvalid", 32'(resp_valid), 32'h1);
        rst       = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        #1;
        check("mr_rvalid", 32'(resp_valid), 32'h0);
        check("mr_ready", 32'(req_ready), 32'h0);
        rst        = 1'b0;
        resp_ready = 1'b1;
        set_op(0, 32'h40000000, 32'h3F800000);
        set_op(3, 32'h3F800000, 32'h40000000);
        #1;
        check("mr_first_grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("mr_no_stale", 32'(resp_valid), 32'h0);
        @(negedge clk);
        #1;
        check("mr_rvalid_new", 32'(resp_valid), 32'h1);
        check("mr_rid_new", 32'(resp_id), 32'h0);
        check("mr_ry_new", 32'(resp_y), 32'h0);
        @(negedge clk);
        #1;
        check("mr_drain", 32'(resp_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
- Shares one combinational `flt` single-precision less-than comparator among NREQ requesters.
- Each requester gets a valid/ready request port. The block arbitrates round-robin, registers operands, evaluates `flt`, and returns the result tagged with the requester ID.
- Two-stage pipeline with output backpressure. Sits between the FPU issue logic and the shared compare datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester ID.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
- req_x1  in  NREQ*32  operand x1 of requester k in bits [32k+31:32k]
- req_x2  in  NREQ*32  operand x2 of requester k in bits [32k+31:32k]
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_id  out  IDW  requester index of the result
- resp_y  out  1  (x1 < x2), IEEE-754 semantics as computed by `flt`
- resp_exception  out  1  NaN operand flag (present only with FCMP_ARB_NAN_EXC_EN)

Behaviour:
- Reset (clk edge with rst=1):
  - s1_valid, resp_valid, resp_id, resp_y, resp_exception all go to 0.
  - Round-robin pointer last_grant goes to NREQ-1, so requester 0 has highest priority first.
  - req_ready is 0 while rst=1.
- Stage advance conditions:
  - s2_adv = !resp_valid || resp_ready.
  - s1_adv = !s1_valid || s2_adv.
- Arbitration (combinational):
  - If s1_adv, grant the first k with req_valid[k]=1, scanning last_grant+1, last_grant+2, … modulo NREQ.
  - req_ready[k]=1 only for the granted k. All zero when s1_adv=0 or no request is pending.
  - req_ready may depend on req_valid; requesters must not depend on req_ready to drive req_valid.
- Accept: on req_valid[k] & req_ready[k] at a clk edge:
  - s1 captures x1, x2 and id=k; s1_valid becomes 1; last_grant becomes k.
  - last_grant does not change when nothing is accepted.
- Stage 1 → 2:
  - `flt(s1_x1, s1_x2, y)` is evaluated combinationally.
  - When s2_adv, the resp_* registers load {s1_valid, s1_id, y}.
  - When s2_adv and s1_valid=0, resp_valid becomes 0 unless a result is held.
- Hold: while resp_valid=1 and resp_ready=0:
  - resp_* stay stable, s1 holds, and no new request is accepted if s1 is full.
- Latency and throughput:
  - An accept at edge t makes resp_valid=1 from edge t+1 onward (second registered stage).
  - Sustained rate is one result per cycle when resp_ready stays high.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- Ordering: results return in accept order; there is no reordering.
- Reset mid-operation: pending s1 and response contents are discarded, with no response emitted. Requesters must re-issue.
- Comparison semantics (from `flt`):
  - -0 < +0 is 0.
  - Any NaN operand gives y=0.
  - Denormals are compared by value.
  - ±inf are ordered normally.

Optional Feature:
- Macro FCMP_ARB_NAN_EXC_EN.
- Defined:
  - resp_exception port exists.
  - resp_exception = (x1[30:23]==8'hFF && x1[22:0]!=0) || (x2[30:23]==8'hFF && x2[22:0]!=0), computed in stage 1.
  - It is registered alongside resp_y and cleared on reset.
- Undefined:
  - Port and logic are absent; resp_y is unchanged.

Decomposition:
- Package fcmp_pkg:
  - FLT_W=32, EXP_MAX=8'hFF.
  - typedef fcmp_req_t {x1, x2}.
  - Function is_nan(logic [31:0]).
- One sub-module: the existing `flt` comparator, instantiated once in stage 1.
- Round-robin grant logic stays inline (rotate, priority-encode, un-rotate).

Test Plan:
- Reset then single request: req_valid=4'b0100, x1=32'h3F800000 (1.0), x2=32'h40000000 (2.0), resp_ready=1 → req_ready=4'b0100 in the same cycle; resp_valid=1, resp_id=2, resp_y=1 two edges after rst deassert+accept; then resp_valid=0.
- All four requesters continuously valid, resp_ready=1 → grants 0,1,2,3,0,… one per cycle; responses back-to-back with ids in grant order.
- Backpressure: fill pipeline, hold resp_ready=0 for 5 cycles → resp_* stable, exactly one more accept fills s1, then req_ready=0; release → two results in order, no loss or duplication.
- Signed zero and infinities:
  - x1=32'h80000000, x2=32'h00000000 → y=0.
  - x1=32'hFF800000, x2=32'h7F7FFFFF → y=1.
  - x1=32'hBF800000, x2=32'hC0000000 → y=0.
- NaN: x1=32'h7FC00000, x2=32'h3F800000 → y=0; resp_exception=1 with FCMP_ARB_NAN_EXC_EN, port absent without it.
- Reset mid-flight: assert rst with s1 and output full → next cycle resp_valid=0, req_ready=0; after release, requester 0 wins first against 0 and 3 both valid.
